// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding, port
// identifiers and the arbitration helper used to pick a winner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_AUX  = 1'b1
  } arb_port_t;

  // Winner among the active requesters; prio breaks a tie when both request.
  function automatic arb_port_t arb_pick(input logic req0, input logic req1,
                                         input arb_port_t prio);
    arb_port_t win;
    if (req0 && req1) begin
      win = prio;
    end else if (req1) begin
      win = PORT_AUX;
    end else begin
      win = PORT_CORE;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous-read memory.
// Each access takes two cycles: S_ACCESS presents the address (and write
// strobe), S_RESP returns the read data and pulses the granted port's ack.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req0/1, we0/1            request and write-enable per port (0 = core, 1 = aux)
//   addr0/1, wdata0/1        access address and write data per port
//   ack0/1                   one-cycle completion pulse per port
//   rdata0/1                 read data, valid only with the matching ack
//   mem_addr, mem_wr_data,
//   mem_wr_ena, mem_rd_data  shared memory port (one-cycle read latency)
//   busy                     high whenever the FSM is not idle
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to replace fixed port-0
// priority with round-robin arbitration on contention.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_ena,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy
);

  arb_state_t        state_q;
  arb_port_t         grant_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wr_data_q;
  logic              mem_wr_ena_q;
  logic              busy_q;

  logic              any_req_c;
  arb_port_t         grant_d;
  logic [ADDR_W-1:0] new_addr_c;
  logic [DATA_W-1:0] new_wdata_c;
  logic              new_we_c;
  logic [ADDR_W-1:0] held_addr_c;

  assign any_req_c = req0 | req1;

  // Arbitration result; only consumed in S_IDLE and S_RESP.
`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_port_t last_grant_q;
  assign grant_d = arb_pick(req0, req1, arb_port_t'(~last_grant_q));
`else
  assign grant_d = arb_pick(req0, req1, PORT_CORE);
`endif

  // Payload of the port about to be granted.
  always_comb begin
    new_addr_c  = addr0;
    new_wdata_c = wdata0;
    new_we_c    = we0;
    if (grant_d == PORT_AUX) begin
      new_addr_c  = addr1;
      new_wdata_c = wdata1;
      new_we_c    = we1;
    end
  end

  // Address of the port already holding the grant (stable until its ack).
  assign held_addr_c = (grant_q == PORT_AUX) ? addr1 : addr0;

  // FSM with grant and all memory-side/ack outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_q       <= PORT_CORE;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_wr_ena_q  <= 1'b0;
      busy_q        <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // Recorded as aux so that port 0 holds priority on the first contention.
      last_grant_q  <= PORT_AUX;
`endif
    end else begin
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mem_wr_ena_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RESP: begin
          if (any_req_c) begin
            state_q       <= S_ACCESS;
            grant_q       <= grant_d;
            mem_addr_q    <= new_addr_c;
            mem_wr_data_q <= new_wdata_c;
            mem_wr_ena_q  <= new_we_c;
            busy_q        <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q  <= grant_d;
`endif
          end else begin
            state_q       <= S_IDLE;
            grant_q       <= PORT_CORE;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            busy_q        <= 1'b0;
          end
        end
        S_ACCESS: begin
          state_q    <= S_RESP;
          mem_addr_q <= held_addr_c;
          ack0_q     <= (grant_q == PORT_CORE);
          ack1_q     <= (grant_q == PORT_AUX);
          busy_q     <= 1'b1;
        end
        default: begin
          state_q       <= S_IDLE;
          grant_q       <= PORT_CORE;
          mem_addr_q    <= '0;
          mem_wr_data_q <= '0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr_ena  = mem_wr_ena_q;
  assign busy        = busy_q;

  // Memory read data arrives during S_RESP, which is exactly the ack cycle.
  assign rdata0 = ack0_q ? mem_rd_data : '0;
  assign rdata1 = ack1_q ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small
// synchronous-read memory model hanging off the shared port.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ena;
  logic [DATA_W-1:0] mem_rd_data;
  logic              busy;

  logic              pre_en;
  logic [ADDR_W-1:0] pre_addr;
  logic [DATA_W-1:0] pre_data;
  logic [DATA_W-1:0] mem_q [0:255];

  int n_tests;
  int n_fail;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack0        (ack0),
    .ack1        (ack1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ena  (mem_wr_ena),
    .mem_rd_data (mem_rd_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: preload port for the bench, write port from the DUT, 1-cycle read.
  always_ff @(posedge clk) begin
    if (pre_en) begin
      mem_q[pre_addr] <= pre_data;
    end else if (mem_wr_ena) begin
      mem_q[mem_addr] <= mem_wr_data;
    end
    mem_rd_data <= mem_q[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_en   = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] exp_d;
    logic              e0, e1;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;

    // Reset state
    tick();
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_ack0",   32'(ack0), 32'd0);
    check("rst_ack1",   32'(ack1), 32'd0);
    check("rst_wr_ena", 32'(mem_wr_ena), 32'd0);
    check("rst_addr",   32'(mem_addr), 32'd0);
    check("rst_wdata",  mem_wr_data, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);

    preload(8'h10, 32'hDEADBEEF);
    preload(8'h11, 32'h11111111);
    preload(8'h12, 32'h22222222);
    rst = 1'b0;

    // Single read from port 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    tick();
    check("rd_access_busy", 32'(busy), 32'd1);
    check("rd_access_addr", 32'(mem_addr), 32'h10);
    check("rd_access_wr",   32'(mem_wr_ena), 32'd0);
    check("rd_access_ack0", 32'(ack0), 32'd0);
    tick();
    check("rd_ack0",   32'(ack0), 32'd1);
    check("rd_rdata0", rdata0, 32'hDEADBEEF);
    check("rd_ack1",   32'(ack1), 32'd0);
    check("rd_rdata1", rdata1, 32'd0);
    req0 = 1'b0;
    tick();
    check("rd_done_ack0", 32'(ack0), 32'd0);
    check("rd_done_busy", 32'(busy), 32'd0);
    check("rd_idle_addr", 32'(mem_addr), 32'd0);

    // Single write from port 1
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 32'h12345678;
    tick();
    check("wr_ena",   32'(mem_wr_ena), 32'd1);
    check("wr_addr",  32'(mem_addr), 32'h20);
    check("wr_data",  mem_wr_data, 32'h12345678);
    check("wr_ack1_early", 32'(ack1), 32'd0);
    tick();
    check("wr_ena_drop", 32'(mem_wr_ena), 32'd0);
    check("wr_ack1",     32'(ack1), 32'd1);
    check("wr_ack0",     32'(ack0), 32'd0);
    req1 = 1'b0; we1 = 1'b0;
    tick();
    check("wr_idle_busy", 32'(busy), 32'd0);
    check("wr_idle_ena",  32'(mem_wr_ena), 32'd0);

    // Read back the written word through port 0
    req0 = 1'b1; addr0 = 8'h20;
    tick();
    tick();
    check("rb_ack0",   32'(ack0), 32'd1);
    check("rb_rdata0", rdata0, 32'h12345678);
    req0 = 1'b0;
    tick();

    // Back-to-back reads on port 0, address bumped at each ack
    req0 = 1'b1; addr0 = 8'h10;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_ack0", 32'(ack0), 32'((k % 2) == 0));
      if ((k % 2) == 0) begin
        case (k)
          2:       exp_d = 32'hDEADBEEF;
          4:       exp_d = 32'h11111111;
          default: exp_d = 32'h22222222;
        endcase
        check("b2b_rdata0", rdata0, exp_d);
        addr0 = addr0 + 8'd1;
      end
    end
    req0 = 1'b0;
    tick();
    check("b2b_idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of a write access
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h30; wdata1 = 32'hCAFEF00D;
    tick();
    check("rmw_ena_before", 32'(mem_wr_ena), 32'd1);
    rst = 1'b1;
    #1;
    check("rmw_ena_async",  32'(mem_wr_ena), 32'd0);
    check("rmw_busy_async", 32'(busy), 32'd0);
    check("rmw_addr_async", 32'(mem_addr), 32'd0);
    tick();
    check("rmw_ack1", 32'(ack1), 32'd0);
    rst = 1'b0;
    we1 = 1'b0; addr1 = 8'h20;
    tick();
    check("rmw_rel1_ack1", 32'(ack1), 32'd0);
    check("rmw_rel1_busy", 32'(busy), 32'd1);
    tick();
    check("rmw_rel2_ack1",   32'(ack1), 32'd1);
    check("rmw_rel2_rdata1", rdata1, 32'h12345678);
    req1 = 1'b0;
    tick();

    // Contention: both ports request for 8 cycles
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
    for (int k = 1; k <= 8; k++) begin
      tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      e0 = ((k % 4) == 2);
      e1 = ((k % 4) == 0);
`else
      e0 = ((k % 2) == 0);
      e1 = 1'b0;
`endif
      check("cont_ack0", 32'(ack0), 32'(e0));
      check("cont_ack1", 32'(ack1), 32'(e1));
      if (e0) check("cont_rdata0", rdata0, 32'hDEADBEEF);
      if (e1) check("cont_rdata1", rdata1, 32'h12345678);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("cont_idle_busy", 32'(busy), 32'd0);

    // Request dropped after grant still completes
    req0 = 1'b1; addr0 = 8'h11;
    tick();
    req0 = 1'b0;
    tick();
    check("drop_ack0",   32'(ack0), 32'd1);
    check("drop_rdata0", rdata0, 32'h11111111);
    tick();
    check("drop_idle_ack0", 32'(ack0), 32'd0);
    check("drop_idle_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: address width of all ports.
REQ-002 The block SHALL have parameter DATA_W, default 32: data width of all ports.
REQ-003 The block SHALL have port clk, input, 1: clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 The block SHALL have ports req0/req1, input, 1 each: access request from port 0 (CPU core) and port 1 (loader/debug).
REQ-006 The block SHALL have ports we0/we1, input, 1 each: 1 = write, 0 = read.
REQ-007 The block SHALL have ports addr0/addr1, input, ADDR_W each: access address.
REQ-008 The block SHALL have ports wdata0/wdata1, input, DATA_W each: write data.
REQ-009 The block SHALL have ports ack0/ack1, output, 1 each: one-cycle completion pulse.
REQ-010 The block SHALL have ports rdata0/rdata1, output, DATA_W each: read data, valid only while the matching ack is high.
REQ-011 The block SHALL have ports mem_addr (output, ADDR_W), mem_wr_data (output, DATA_W), mem_wr_ena (output, 1) and mem_rd_data (input, DATA_W): shared memory, synchronous read, one-cycle latency.
REQ-012 The block SHALL have port busy, output, 1: high whenever the state is not S_IDLE.

Function
REQ-013 The FSM SHALL have three states: S_IDLE, S_ACCESS and S_RESP.
  - S_IDLE: no grant.
  - S_ACCESS: drives mem_addr and mem_wr_data from the granted port; mem_wr_ena = granted we.
  - S_RESP: drives mem_addr from the granted port, holds mem_wr_ena low, and asserts ack of the granted port.
REQ-014 Transitions:
  - S_IDLE to S_ACCESS on any req.
  - S_ACCESS to S_RESP unconditionally.
  - S_RESP to S_ACCESS if any req is high in that cycle, otherwise to S_IDLE.
REQ-015 Arbitration SHALL occur only in S_IDLE and S_RESP; the grant SHALL be registered on the S_ACCESS entry edge and held until S_RESP exits.
REQ-016 Latency from req sampled in S_IDLE to ack SHALL be exactly 2 cycles; back-to-back sustained throughput SHALL be one access per 2 cycles.
REQ-017 rdataN SHALL equal mem_rd_data combinationally during S_RESP for the granted port and SHALL be 0 otherwise.
REQ-018 A requester SHALL hold req, we, addr and wdata stable until its ack; req high during its own ack cycle SHALL be treated as a new request with the values then presented.
REQ-019 mem_wr_ena SHALL be high for exactly one cycle per write access and never in S_IDLE or S_RESP.
REQ-020 mem_addr and mem_wr_data SHALL be 0 in S_IDLE.
REQ-021 When both req are high at an arbitration point, port 0 SHALL win, unless the round-robin feature is compiled in (REQ-026).
REQ-022 A request dropped before grant SHALL be ignored; a request dropped after grant SHALL still complete, and the ack SHALL still pulse.
REQ-023 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-024 On rst the block SHALL immediately set the state to S_IDLE, clear the grant, set ack0/ack1/mem_wr_ena/busy to 0, set rdata0/rdata1/mem_addr/mem_wr_data to 0, and set the round-robin pointer to port 0.
REQ-025 Reset mid-access SHALL abort the access with no ack and no further write; the first request after release SHALL follow REQ-016 timing.

Configuration
REQ-026 With MEM_ARB_ROUND_ROBIN_EN defined, a last_grant register SHALL be updated at each grant, and on contention the port not granted last SHALL win.
REQ-027 Without MEM_ARB_ROUND_ROBIN_EN, fixed priority (port 0) SHALL apply and no last_grant register SHALL exist.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the arb_state_t enum (S_IDLE, S_ACCESS, S_RESP) and the arb_port_t typedef (PORT_CORE = 0, PORT_AUX = 1).
REQ-029 The block SHALL be a single module with no sub-module; the grant register SHALL use the existing register block.

Verification
REQ-030 Single read: req0=1, we0=0, addr0=0x10, memory[0x10]=0xDEADBEEF -> ack0 in the 2nd cycle with rdata0=0xDEADBEEF; ack1 stays 0.
REQ-031 Single write: req1=1, we1=1, addr1=0x20, wdata1=0x12345678 -> mem_wr_ena high for exactly one cycle with mem_addr=0x20 and mem_wr_data=0x12345678; ack1 one cycle later.
REQ-032 Contention: req0 and req1 held high for 8 cycles -> fixed-priority build yields acks all port 0; round-robin build yields acks alternating 0,1,0,1.
REQ-033 Back-to-back: req0 held with addr incremented at each ack -> one ack every 2 cycles and busy continuously high.
REQ-034 Reset mid-write: rst asserted during S_ACCESS -> mem_wr_ena drops to 0 immediately, no ack, state S_IDLE; the next request is acked 2 cycles after release.
